// File: rtl/exu_wb_pkg.sv
// Shared types and defaults for the execution-unit writeback arbiter.
package exu_wb_pkg;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_DIV,
      SRC_RSR
   } src_e;

   localparam int unsigned DW_DEF      = 72;
   localparam int unsigned AGE_MAX_DEF = 4;
   localparam int unsigned AGE_W       = 3;

endpackage

// File: rtl/exu_wb_age_ctr.sv
// Wait-age counter for one deferrable writeback requester; flags when the
// requester has waited long enough that the pipeline must be held off.
module exu_wb_age_ctr
   import exu_wb_pkg::*;
#(
   parameter int unsigned AGE_MAX = AGE_MAX_DEF
) (
   input  logic clk,
   input  logic rst_l,
   input  logic req_i,
   input  logic gnt_i,
   output logic hit_o
);

   localparam logic [AGE_W-1:0] Thresh = AGE_W'(AGE_MAX - 1);
   localparam logic [AGE_W-1:0] Sat    = '1;

   logic [AGE_W-1:0] age_q, age_d;
   logic             waiting;

   assign waiting = req_i & ~gnt_i;

   always_comb begin
      age_d = '0;
      if (waiting) begin
         age_d = (age_q == Sat) ? age_q : age_q + AGE_W'(1);
      end
   end

   assign hit_o = waiting & (age_q >= Thresh);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/exu_wb_arb.sv
// Integer register-file writeback arbiter: pipeline ALU results always win,
// divider and restore results share the leftover slots round-robin.
module exu_wb_arb
   import exu_wb_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned AGE_MAX = AGE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          alu_vld,
   input  logic [4:0]    alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          div_req,
   input  logic [4:0]    div_rd,
   input  logic [DW-1:0] div_data,
   input  logic          rsr_req,
   input  logic [4:0]    rsr_rd,
   input  logic [DW-1:0] rsr_data,
   output logic          div_ack,
   output logic          rsr_ack,
   output logic          pipe_hold,
   output logic          irf_wen,
   output logic [4:0]    irf_rd,
   output logic [DW-1:0] irf_data,
   output logic          err_hold_viol
);

   src_e          sel;
   logic          div_gnt, rsr_gnt;
   logic          ptr_q, ptr_d;  // 0 = divider next, 1 = restore next
   logic          div_hit, rsr_hit;
   logic          hold_q, hold_d;
   logic          err_q, err_d;
   logic          wen_q, wen_d;
   logic [4:0]    rd_q, rd_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      sel     = SRC_NONE;
      div_gnt = 1'b0;
      rsr_gnt = 1'b0;
      if (alu_vld) begin
         sel = SRC_ALU;
      end else if (div_req && (!rsr_req || !ptr_q)) begin
         sel     = SRC_DIV;
         div_gnt = 1'b1;
      end else if (rsr_req) begin
         sel     = SRC_RSR;
         rsr_gnt = 1'b1;
      end
   end

   // Acks are masked while reset is asserted so nothing pending is consumed.
   assign div_ack = div_gnt & rst_l;
   assign rsr_ack = rsr_gnt & rst_l;

   always_comb begin
      ptr_d = ptr_q;
      if (div_gnt) begin
         ptr_d = 1'b1;
      end else if (rsr_gnt) begin
         ptr_d = 1'b0;
      end
   end

   exu_wb_age_ctr #(
      .AGE_MAX (AGE_MAX)
   ) u_div_age (
      .clk   (clk),
      .rst_l (rst_l),
      .req_i (div_req),
      .gnt_i (div_gnt),
      .hit_o (div_hit)
   );

   exu_wb_age_ctr #(
      .AGE_MAX (AGE_MAX)
   ) u_rsr_age (
      .clk   (clk),
      .rst_l (rst_l),
      .req_i (rsr_req),
      .gnt_i (rsr_gnt),
      .hit_o (rsr_hit)
   );

   assign hold_d = div_hit | rsr_hit;
   assign err_d  = err_q | (hold_q & alu_vld);

   always_comb begin
      wen_d  = 1'b1;
      rd_d   = rd_q;
      data_d = data_q;
      unique case (sel)
         SRC_ALU: begin
            rd_d   = alu_rd;
            data_d = alu_data;
         end
         SRC_DIV: begin
            rd_d   = div_rd;
            data_d = div_data;
         end
         SRC_RSR: begin
            rd_d   = rsr_rd;
            data_d = rsr_data;
         end
         default: wen_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ptr_q  <= 1'b0;
         hold_q <= 1'b0;
         err_q  <= 1'b0;
         wen_q  <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         hold_q <= hold_d;
         err_q  <= err_d;
         wen_q  <= wen_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign pipe_hold     = hold_q;
   assign err_hold_viol = err_q;
   assign irf_wen       = wen_q;
   assign irf_rd        = rd_q;
   assign irf_data      = data_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Self-checking bench for exu_wb_arb: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_exu_wb_arb;
   import exu_wb_pkg::*;

   localparam int unsigned DW      = 72;
   localparam int          AGE_MAX = 4;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          alu_vld = 1'b0;
   logic [4:0]    alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          div_req = 1'b0;
   logic [4:0]    div_rd = '0;
   logic [DW-1:0] div_data = '0;
   logic          rsr_req = 1'b0;
   logic [4:0]    rsr_rd = '0;
   logic [DW-1:0] rsr_data = '0;
   logic          div_ack, rsr_ack, pipe_hold, irf_wen, err_hold_viol;
   logic [4:0]    irf_rd;
   logic [DW-1:0] irf_data;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   int            m_ptr;      // 0: divider preferred on a tie, 1: restore
   int            m_age_div, m_age_rsr;
   bit            m_hold, m_err, m_wen;
   logic [4:0]    m_rd;
   logic [DW-1:0] m_data;

   exu_wb_arb #(
      .DW      (DW),
      .AGE_MAX (AGE_MAX)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .alu_vld       (alu_vld),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .div_req       (div_req),
      .div_rd        (div_rd),
      .div_data      (div_data),
      .rsr_req       (rsr_req),
      .rsr_rd        (rsr_rd),
      .rsr_data      (rsr_data),
      .div_ack       (div_ack),
      .rsr_ack       (rsr_ack),
      .pipe_hold     (pipe_hold),
      .irf_wen       (irf_wen),
      .irf_rd        (irf_rd),
      .irf_data      (irf_data),
      .err_hold_viol (err_hold_viol)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_age_div = 0; m_age_rsr = 0;
      m_hold = 0; m_err = 0; m_wen = 0; m_rd = '0; m_data = '0;
   endtask

   function automatic void exp_grant(output bit ga, output bit gd, output bit gr);
      ga = alu_vld; gd = 0; gr = 0;
      if (!alu_vld) begin
         if (div_req && rsr_req) begin
            gd = (m_ptr == 0);
            gr = (m_ptr == 1);
         end else begin
            gd = div_req;
            gr = rsr_req;
         end
      end
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit ga, gd, gr, old_hold;
      exp_grant(ga, gd, gr);
      old_hold = m_hold;
      m_hold = (div_req && !gd && m_age_div >= AGE_MAX - 1) ||
               (rsr_req && !gr && m_age_rsr >= AGE_MAX - 1);
      m_age_div = (div_req && !gd) ? ((m_age_div < 7) ? m_age_div + 1 : 7) : 0;
      m_age_rsr = (rsr_req && !gr) ? ((m_age_rsr < 7) ? m_age_rsr + 1 : 7) : 0;
      if (gd) m_ptr = 1;
      if (gr) m_ptr = 0;
      m_err = m_err || (old_hold && alu_vld);
      m_wen = ga || gd || gr;
      if (ga) begin m_rd = alu_rd; m_data = alu_data; end
      if (gd) begin m_rd = div_rd; m_data = div_data; end
      if (gr) begin m_rd = rsr_rd; m_data = rsr_data; end
   endtask

   task automatic idle_inputs();
      alu_vld = 0; div_req = 0; rsr_req = 0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst_l = 0;
      #1;
      tick();
      rst_l = 1;
      model_reset();
   endtask

   task automatic test_reset();
      idle_inputs();
      div_req = 1; div_rd = 5'd17; div_data = 72'h55;
      rst_l = 0;
      #2;
      n_cmp++; if (irf_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %0h want 0", irf_wen); end
      n_cmp++; if (irf_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got %0h want 0", irf_rd); end
      n_cmp++; if (irf_data !== '0) begin n_fail++; $display("FAIL rst_data got %0h want 0", irf_data); end
      n_cmp++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold got %0h want 0", pipe_hold); end
      n_cmp++; if (err_hold_viol !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0h want 0", err_hold_viol); end
      n_cmp++; if (div_ack !== 1'b0) begin n_fail++; $display("FAIL rst_div_ack got %0h want 0", div_ack); end
      tick();
      n_cmp++; if (irf_wen !== 1'b0) begin n_fail++; $display("FAIL rst_no_write got %0h want 0", irf_wen); end
      rst_l = 1;
      #1;
      n_cmp++; if (div_ack !== 1'b1) begin n_fail++; $display("FAIL rel_div_ack got %0h want 1", div_ack); end
      tick();
      div_req = 0;
      n_cmp++; if (irf_wen !== 1'b1 || irf_rd !== 5'd17) begin
         n_fail++; $display("FAIL first_grant wen/rd got %0h/%0h want 1/11", irf_wen, irf_rd); end
   endtask

   task automatic test_single_div();
      reset_dut();
      div_req = 1; div_rd = 5'd5; div_data = 72'hAA;
      #1;
      n_cmp++; if (div_ack !== 1'b1 || rsr_ack !== 1'b0) begin
         n_fail++; $display("FAIL single_ack div/rsr got %0h/%0h want 1/0", div_ack, rsr_ack); end
      tick();
      div_req = 0;
      n_cmp++; if (irf_wen !== 1'b1) begin n_fail++; $display("FAIL single_wen got %0h want 1", irf_wen); end
      n_cmp++; if (irf_rd !== 5'd5) begin n_fail++; $display("FAIL single_rd got %0h want 5", irf_rd); end
      n_cmp++; if (irf_data !== 72'hAA) begin n_fail++; $display("FAIL single_data got %0h want aa", irf_data); end
      tick();
      n_cmp++; if (irf_wen !== 1'b0 || irf_rd !== 5'd5 || irf_data !== 72'hAA) begin
         n_fail++; $display("FAIL idle_hold wen/rd/data got %0h/%0h/%0h want 0/5/aa", irf_wen, irf_rd, irf_data); end
   endtask

   task automatic test_hold();
      reset_dut();
      alu_vld = 1; alu_rd = 5'd3; alu_data = 72'h111;
      div_req = 1; div_rd = 5'd9; div_data = 72'h222;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (div_ack !== 1'b0 || pipe_hold !== 1'b0) begin
            n_fail++; $display("FAIL hold_pre c%0d ack/hold got %0h/%0h want 0/0", c, div_ack, pipe_hold); end
         tick();
         n_cmp++; if (irf_wen !== 1'b1 || irf_rd !== 5'd3) begin
            n_fail++; $display("FAIL hold_alu c%0d wen/rd got %0h/%0h want 1/3", c, irf_wen, irf_rd); end
      end
      n_cmp++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL hold_c4 got %0h want 1", pipe_hold); end
      alu_vld = 0;
      #1;
      n_cmp++; if (div_ack !== 1'b1) begin n_fail++; $display("FAIL hold_ack got %0h want 1", div_ack); end
      tick();
      div_req = 0;
      n_cmp++; if (irf_wen !== 1'b1 || irf_rd !== 5'd9 || irf_data !== 72'h222) begin
         n_fail++; $display("FAIL hold_div_wr wen/rd/data got %0h/%0h/%0h want 1/9/222", irf_wen, irf_rd, irf_data); end
      n_cmp++; if (pipe_hold !== 1'b0 || err_hold_viol !== 1'b0) begin
         n_fail++; $display("FAIL hold_after hold/err got %0h/%0h want 0/0", pipe_hold, err_hold_viol); end
   endtask

   task automatic test_round_robin();
      reset_dut();
      div_req = 1; div_rd = 5'd1; div_data = 72'h1;
      rsr_req = 1; rsr_rd = 5'd2; rsr_data = 72'h2;
      #1;
      n_cmp++; if (div_ack !== 1'b1 || rsr_ack !== 1'b0) begin
         n_fail++; $display("FAIL rr_c0 div/rsr got %0h/%0h want 1/0", div_ack, rsr_ack); end
      tick();
      n_cmp++; if (irf_rd !== 5'd1) begin n_fail++; $display("FAIL rr_wr0 got %0h want 1", irf_rd); end
      #1;
      n_cmp++; if (div_ack !== 1'b0 || rsr_ack !== 1'b1) begin
         n_fail++; $display("FAIL rr_c1 div/rsr got %0h/%0h want 0/1", div_ack, rsr_ack); end
      tick();
      n_cmp++; if (irf_rd !== 5'd2) begin n_fail++; $display("FAIL rr_wr1 got %0h want 2", irf_rd); end
      #1;
      n_cmp++; if (div_ack !== 1'b1 || rsr_ack !== 1'b0) begin
         n_fail++; $display("FAIL rr_c2 div/rsr got %0h/%0h want 1/0", div_ack, rsr_ack); end
      tick();
      // Divider was last served, so the next tie goes to restore.
      #1;
      n_cmp++; if (div_ack !== 1'b0 || rsr_ack !== 1'b1) begin
         n_fail++; $display("FAIL rr_c3 div/rsr got %0h/%0h want 0/1", div_ack, rsr_ack); end
      tick();
      idle_inputs();
   endtask

   task automatic test_err();
      reset_dut();
      alu_vld = 1; alu_rd = 5'd7; alu_data = 72'h777;
      div_req = 1; div_rd = 5'd8; div_data = 72'h888;
      repeat (4) tick();
      n_cmp++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL err_hold got %0h want 1", pipe_hold); end
      #1;
      n_cmp++; if (div_ack !== 1'b0) begin n_fail++; $display("FAIL err_alu_wins got %0h want 0", div_ack); end
      tick();
      alu_vld = 0;
      n_cmp++; if (irf_wen !== 1'b1 || irf_rd !== 5'd7) begin
         n_fail++; $display("FAIL err_alu_wr wen/rd got %0h/%0h want 1/7", irf_wen, irf_rd); end
      n_cmp++; if (err_hold_viol !== 1'b1) begin n_fail++; $display("FAIL err_set got %0h want 1", err_hold_viol); end
      tick();
      div_req = 0;
      repeat (3) tick();
      n_cmp++; if (err_hold_viol !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0h want 1", err_hold_viol); end
      rst_l = 0;
      #1;
      n_cmp++; if (err_hold_viol !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0h want 0", err_hold_viol); end
      rst_l = 1;
   endtask

   task automatic test_async_reset();
      reset_dut();
      alu_vld = 1; alu_rd = 5'd4; alu_data = 72'h444;
      rsr_req = 1; rsr_rd = 5'd12; rsr_data = 72'h333;
      tick();
      n_cmp++; if (irf_wen !== 1'b1) begin n_fail++; $display("FAIL ar_pre_wen got %0h want 1", irf_wen); end
      #2;
      rst_l = 0;
      #1;
      n_cmp++; if (irf_wen !== 1'b0 || irf_rd !== 5'd0 || irf_data !== '0) begin
         n_fail++; $display("FAIL ar_async wen/rd/data got %0h/%0h/%0h want 0/0/0", irf_wen, irf_rd, irf_data); end
      n_cmp++; if (rsr_ack !== 1'b0 || pipe_hold !== 1'b0 || err_hold_viol !== 1'b0) begin
         n_fail++; $display("FAIL ar_async ack/hold/err got %0h/%0h/%0h want 0/0/0", rsr_ack, pipe_hold, err_hold_viol); end
      alu_vld = 0;
      tick();
      n_cmp++; if (irf_wen !== 1'b0) begin n_fail++; $display("FAIL ar_no_write got %0h want 0", irf_wen); end
      rst_l = 1;
      div_req = 1; div_rd = 5'd13; div_data = 72'h555;
      #1;
      // Pointer is back at the divider, so a tie right after release goes to it.
      n_cmp++; if (div_ack !== 1'b1 || rsr_ack !== 1'b0) begin
         n_fail++; $display("FAIL ar_ptr div/rsr got %0h/%0h want 1/0", div_ack, rsr_ack); end
      div_req = 0;
      #1;
      n_cmp++; if (rsr_ack !== 1'b1) begin n_fail++; $display("FAIL ar_rsr_ack got %0h want 1", rsr_ack); end
      tick();
      rsr_req = 0;
      n_cmp++; if (irf_wen !== 1'b1 || irf_rd !== 5'd12 || irf_data !== 72'h333) begin
         n_fail++; $display("FAIL ar_rsr_wr wen/rd/data got %0h/%0h/%0h want 1/c/333", irf_wen, irf_rd, irf_data); end
   endtask

   task automatic test_random();
      int  w_div, w_rsr;
      bit  ga, gd, gr, gd_prev, gr_prev;
      reset_dut();
      w_div = 0; w_rsr = 0; gd_prev = 0; gr_prev = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         alu_vld = !m_hold && ($urandom_range(0, 99) < 45);
         alu_rd = 5'($urandom); alu_data = DW'({$urandom(), $urandom(), $urandom()});
         if (gd_prev) div_req = 0;
         if (div_req && $urandom_range(0, 39) == 0) div_req = 0;
         else if (!div_req && $urandom_range(0, 2) == 0) begin
            div_req = 1; w_div = 0;
            div_rd = 5'($urandom); div_data = DW'({$urandom(), $urandom(), $urandom()});
         end
         if (gr_prev) rsr_req = 0;
         if (rsr_req && $urandom_range(0, 39) == 0) rsr_req = 0;
         else if (!rsr_req && $urandom_range(0, 2) == 0) begin
            rsr_req = 1; w_rsr = 0;
            rsr_rd = 5'($urandom); rsr_data = DW'({$urandom(), $urandom(), $urandom()});
         end
         #1;
         exp_grant(ga, gd, gr);
         n_cmp++; if (div_ack !== gd || rsr_ack !== gr) begin
            n_fail++; $display("FAIL rnd_ack cyc%0d div/rsr got %0h/%0h want %0h/%0h", cyc, div_ack, rsr_ack, gd, gr); end
         n_cmp++; if (int'(alu_vld) + int'(div_ack) + int'(rsr_ack) > 1) begin
            n_fail++; $display("FAIL rnd_onegrant cyc%0d alu/div/rsr got %0h/%0h/%0h want at most one", cyc, alu_vld, div_ack, rsr_ack); end
         if (gd) begin
            n_cmp++; if (w_div > 10) begin n_fail++; $display("FAIL rnd_div_wait got %0d want <=10", w_div); end
         end
         if (gr) begin
            n_cmp++; if (w_rsr > 10) begin n_fail++; $display("FAIL rnd_rsr_wait got %0d want <=10", w_rsr); end
         end
         tick();
         model_step();
         if (div_req && !gd) w_div++;
         if (rsr_req && !gr) w_rsr++;
         gd_prev = gd; gr_prev = gr;
         n_cmp++; if (irf_wen !== m_wen || irf_rd !== m_rd || irf_data !== m_data) begin
            n_fail++; $display("FAIL rnd_wr cyc%0d wen/rd/data got %0h/%0h/%0h want %0h/%0h/%0h",
                               cyc, irf_wen, irf_rd, irf_data, m_wen, m_rd, m_data); end
         n_cmp++; if (pipe_hold !== m_hold || err_hold_viol !== m_err) begin
            n_fail++; $display("FAIL rnd_hold cyc%0d hold/err got %0h/%0h want %0h/%0h",
                               cyc, pipe_hold, err_hold_viol, m_hold, m_err); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_div();
      test_hold();
      test_round_robin();
      test_err();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
